// File: rtl/adder_pkg.sv
// adder_pkg: shared stage-count helper, saturation limit generators and per-stage control bundle
package adder_pkg;

    localparam int MAX_W = 1024;

    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } ctl_t;

    function automatic int stages(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int width);
        return MAX_W'(1) << (width - 1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_pos(input int width);
        return sat_neg(width) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/pipelined_adder_n_if.sv
// pipelined_adder_n_if: operand/result valid-ready bundle for pipelined_adder_n
interface pipelined_adder_n_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/adder_seg.sv
// adder_seg: SEG-bit ripple segment chained from full_adder cells; also exposes the carry into its MSB
module adder_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] A,
    input  logic [SEG-1:0] B,
    input  logic           Cin,
    output logic [SEG-1:0] S,
    output logic           Cout,
    output logic           Cmsb
);
    logic [SEG:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(S[i]), .co(c[i+1]));
    end

    assign Cout = c[SEG];
    assign Cmsb = c[SEG-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: 1-bit full-adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_adder_n.sv
// pipelined_adder_n: WIDTH-bit add/subtract resolved SEG bits per pipeline stage; define ADDER_SAT_EN for signed saturation
module pipelined_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_n_if.slave io
);
    localparam int STAGES = stages(WIDTH, SEG);
    localparam int L      = STAGES - 1;

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_adder_n: WIDTH must be a multiple of SEG");
    end

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

    // Row k holds a beat after segment k is resolved: full operands ride along (upper segments
    // still pending) and the result accumulates lower segments until it leaves aligned.
    ctl_t             ctl_q [STAGES];
    ctl_t             ctl_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             ovf_q, ovf_d;

    logic [STAGES-1:0]            ld, v_in, sub_in, c_in;
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in;
    logic [SEG-1:0]               seg_s  [STAGES];
    logic                         seg_co [STAGES];
    logic                         seg_cm [STAGES];
    logic                         nxt;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k]   = io.in_valid;
            assign a_in[k]   = io.A;
            assign b_in[k]   = io.Sub ? ~io.B : io.B;
            assign c_in[k]   = io.Sub ^ io.Cin;
            assign sub_in[k] = io.Sub;
            assign s_in[k]   = '0;
        end else begin : g_body
            assign v_in[k]   = ctl_q[k-1].valid;
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = ctl_q[k-1].carry;
            assign sub_in[k] = ctl_q[k-1].sub;
            assign s_in[k]   = s_q[k-1];
        end
        adder_seg #(.SEG(SEG)) u_seg (
            .A    (a_in[k][k*SEG +: SEG]),
            .B    (b_in[k][k*SEG +: SEG]),
            .Cin  (c_in[k]),
            .S    (seg_s[k]),
            .Cout (seg_co[k]),
            .Cmsb (seg_cm[k])
        );
    end

    // Global stall chain from the output back, then per-row load of the resolved segment
    always_comb begin
        nxt = io.out_ready;
        for (int k = L; k >= 0; k--) begin
            ld[k] = !ctl_q[k].valid | nxt;
            nxt   = ld[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            ctl_d[k].valid = ld[k] ? v_in[k] : ctl_q[k].valid;
            ctl_d[k].sub   = (ld[k] & v_in[k]) ? sub_in[k] : ctl_q[k].sub;
            ctl_d[k].carry = (ld[k] & v_in[k]) ? seg_co[k] : ctl_q[k].carry;
            a_d[k]         = (ld[k] & v_in[k]) ? a_in[k] : a_q[k];
            b_d[k]         = (ld[k] & v_in[k]) ? b_in[k] : b_q[k];
            s_d[k]         = (ld[k] & v_in[k]) ? s_in[k] : s_q[k];
            if (ld[k] & v_in[k]) s_d[k][k*SEG +: SEG] = seg_s[k];
        end
        ovf_d = (ld[L] & v_in[L]) ? (seg_cm[L] ^ seg_co[L]) : ovf_q;
`ifdef ADDER_SAT_EN
        if (ld[L] & v_in[L] & ovf_d) s_d[L] = a_in[L][WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
    end

    // Pipeline rows; reset drops every in-flight beat and zeroes the presented result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            ctl_q <= ctl_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

    assign io.in_ready  = ld[0];
    assign io.out_valid = ctl_q[L].valid;
    assign io.S         = s_q[L];
    assign io.Cout      = ctl_q[L].carry;
    assign io.Ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_n.sv
// tb_pipelined_adder_n: scoreboard bench for pipelined_adder_n (WIDTH=32, SEG=8)
module tb_pipelined_adder_n;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        bit          lat;
        int          cyc;
        int          id;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic [31:0] ssat;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nid = 0;
    bit   rnd_mode = 1'b0;
    logic or_val = 1'b1;
    exp_t sb[$];
    vec_t tbl [12];

    pipelined_adder_n_if #(.WIDTH(32)) ifc ();

    pipelined_adder_n #(.WIDTH(32), .SEG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        exp_t   e;
        longint sa, sbv, m;
        e   = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        m   = sub ? sa - sbv - longint'(cin) : sa + sbv + longint'(cin);
        e.s = m[31:0];
        e.ovf = (m > 64'sd2147483647) || (m < -64'sd2147483648);
        e.cout = sub ? ({1'b0, a} >= ({1'b0, b} + {32'b0, cin}))
                     : (({1'b0, a} + {1'b0, b} + {32'b0, cin}) >> 32) != 33'd0;
`ifdef ADDER_SAT_EN
        if (e.ovf) e.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        input exp_t e, input bit lat, input bit push);
        int w;
        w = 0;
        ifc.A = a;
        ifc.B = b;
        ifc.Cin = cin;
        ifc.Sub = sub;
        ifc.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (lat && w == 0) chk("stream_in_ready", 32'(ifc.in_ready), 32'd1);
            if (ifc.in_ready) begin
                if (push) begin
                    e.lat = lat;
                    e.cyc = cyc;
                    e.id = nid;
                    sb.push_back(e);
                end
                nid++;
                break;
            end
            w++;
            if (w > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout id=%0d got in_ready=0 want 1", nid);
                break;
            end
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t v, input bit lat);
        exp_t e;
        e = '0;
`ifdef ADDER_SAT_EN
        e.s = v.ssat;
`else
        e.s = v.s;
`endif
        e.cout = v.cout;
        e.ovf = v.ovf;
        send(v.a, v.b, v.cin, v.sub, e, lat, 1'b1);
    endtask

    task automatic send_rnd(input bit lat);
        logic [31:0] a, b;
        logic cin, sub;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        send(a, b, cin, sub, model(a, b, cin, sub), lat, 1'b1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Sink: out_ready either follows or_val or is randomly low about 30% of cycles
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ifc.out_ready = rnd_mode ? ($urandom_range(0, 9) >= 3) : or_val;
        end
    end

    // Monitor: pops the scoreboard on every produced beat and checks stall stability
    bit          prev_stall = 1'b0;
    logic [31:0] hold_s;
    logic        hold_c, hold_o;
    exp_t        got;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!(ifc.out_valid && ifc.S == hold_s && ifc.Cout == hold_c && ifc.Ovf == hold_o)) begin
                    bad++;
                    $display("FAIL stall_hold got v=%b S=%h C=%b O=%b want v=1 S=%h C=%b O=%b",
                             ifc.out_valid, ifc.S, ifc.Cout, ifc.Ovf, hold_s, hold_c, hold_o);
                end
            end
            if (ifc.out_valid && ifc.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat got S=%h want no output", ifc.S);
                end else begin
                    got = sb.pop_front();
                    if (ifc.S !== got.s || ifc.Cout !== got.cout || ifc.Ovf !== got.ovf) begin
                        bad++;
                        $display("FAIL result id=%0d got S=%h Cout=%b Ovf=%b want S=%h Cout=%b Ovf=%b",
                                 got.id, ifc.S, ifc.Cout, ifc.Ovf, got.s, got.cout, got.ovf);
                    end
                    if (got.lat) begin
                        total++;
                        if (cyc - got.cyc != 4) begin
                            bad++;
                            $display("FAIL latency id=%0d got=%0d want=4", got.id, cyc - got.cyc);
                        end
                    end
                end
            end
            prev_stall = ifc.out_valid && !ifc.out_ready;
            hold_s = ifc.S;
            hold_c = ifc.Cout;
            hold_o = ifc.Ovf;
        end
    end

    initial begin
        //          a             b             cin   sub   s (wrap)      s (sat)       cout  ovf
        tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b0};
        tbl[3]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 32'h2345_678A, 1'b0, 1'b0};
        tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        tbl[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000_0010, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
        tbl[8]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0};
        tbl[9]  = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0};
        tbl[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[11] = '{32'h0000_FF00, 32'h0000_FF01, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.A = '0;
        ifc.B = '0;
        ifc.Cin = 1'b0;
        ifc.Sub = 1'b0;
        ifc.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_S", ifc.S, 32'd0);
        chk("rst_Cout_Ovf", {30'd0, ifc.Cout, ifc.Ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) send_vec(tbl[i], 1'b1);
        for (int i = 0; i < 100; i++) send_rnd(1'b1);
        wait_drain();

        rnd_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            if (i % 10 == 0) send_vec(tbl[(i / 10) % 12], 1'b0);
            else send_rnd(1'b0);
        end
        rnd_mode = 1'b0;
        or_val = 1'b1;
        wait_drain();

        or_val = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(tbl[i + 4], 1'b0);
        ifc.A = tbl[8].a;
        ifc.B = tbl[8].b;
        ifc.Cin = tbl[8].cin;
        ifc.Sub = tbl[8].sub;
        ifc.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
        end
        or_val = 1'b1;
        send_vec(tbl[8], 1'b0);
        wait_drain();

        or_val = 1'b0;
        for (int i = 0; i < 3; i++) send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_pre_out_valid", 32'(ifc.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("flush_S", ifc.S, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        or_val = 1'b1;
        @(posedge clk);
        #1;
        send_vec(tbl[3], 1'b1);
        wait_drain();
        repeat (6) @(negedge clk);
        chk("final_out_valid", 32'(ifc.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
